// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one combinational 4x4 array multiplier between two
// requesters. A round-robin pointer picks the winner when both ask at once.
// Each operation runs IDLE (grant + operand latch) -> CALC (array settles,
// product registered) -> DONE (completion pulse to the owner).
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   req0/a0/b0      requester 0 level request and operands
//   req1/a1/b1      requester 1 level request and operands
//   gnt[1:0]        one-hot grant, combinational pulse in the latch cycle
//   done[1:0]       one-hot completion pulse, p valid in the same cycle
//   p[7:0]          registered product of the last completed operation
//   owner           requester that owns p
//   busy            high in CALC and DONE
//   op_count        completed operations, saturating
module mult_share_ctrl #(
  parameter int FIRST_PRIO = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  input  logic             req1,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [7:0]       p,
  output logic             owner,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [3:0]       opa, opb;
  logic             own_q, prio;
  logic [7:0]       prod, p_q;
  logic [CNT_W-1:0] cnt;
  logic             win, grant;

  // Array multiplier: sum of shifted partial-product rows. Only the latched
  // operands feed it, so requester inputs are isolated after the grant.
  always_comb begin
    prod = 8'd0;
    for (int i = 0; i < 4; i++)
      prod = prod + ({4'd0, opa & {4{opb[i]}}} << i);
  end

  always_comb begin
    state_nx = state;
    gnt      = 2'b00;
    grant    = 1'b0;
    win      = prio;
    case (state)
      IDLE: begin
        // Pointer only matters on contention; a lone request always wins.
        win   = (req0 && req1) ? prio : req1;
        grant = req0 | req1;
        if (grant) begin
          gnt      = win ? 2'b10 : 2'b01;
          state_nx = CALC;
        end
      end
      CALC:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opa   <= 4'd0;
      opb   <= 4'd0;
      own_q <= 1'b0;
      prio  <= 1'(FIRST_PRIO);
      p_q   <= 8'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant) begin
        opa   <= win ? a1 : a0;
        opb   <= win ? b1 : b0;
        own_q <= win;
      end
      if (state == CALC) p_q <= prod;
      if (state == DONE) begin
        prio <= ~own_q;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  assign done     = (state == DONE) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state == CALC) || (state == DONE);
  assign p        = p_q;
  assign owner    = own_q;
  assign op_count = cnt;

endmodule
